// File: rtl/stepper_multi_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : stepper_multi_ctrl
// Brief    : NUM_CH independent stepper channels with per-move command
//            handshake, programmable step period, full/half step and hold.
// Revision : 1.0
// ============================================================================
module stepper_multi_ctrl #(
  parameter int NUM_CH  = 2,
  parameter int PHASE_W = 6,
  parameter int DIV_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         cmd_valid,
  output logic [NUM_CH-1:0]         cmd_ready,
  input  logic [NUM_CH*CNT_W-1:0]   cmd_steps,
  input  logic [NUM_CH*DIV_W-1:0]   cmd_period,
  input  logic [NUM_CH-1:0]         cmd_dir,
  input  logic [NUM_CH-1:0]         cmd_half,
  input  logic [NUM_CH-1:0]         cmd_hold,
  input  logic [NUM_CH-1:0]         abort,
  output logic [NUM_CH*PHASE_W-1:0] state_out,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         done,
  output logic [NUM_CH*CNT_W-1:0]   pos
);

  localparam int IDX_N = 2 * PHASE_W;
  localparam int IDX_W = $clog2(IDX_N);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  // Even index drives one coil, odd index drives the two neighbouring coils.
  function automatic logic [PHASE_W-1:0] f_pattern(input logic [IDX_W-1:0] idx);
    logic [PHASE_W-1:0] p;
    int lo;
    int hi;
    lo = int'(idx) >> 1;
    hi = (lo + 1 == PHASE_W) ? 0 : lo + 1;
    for (int b = 0; b < PHASE_W; b++) begin
      p[b] = (b == lo) | (idx[0] & (b == hi));
    end
    return p;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t             r_state;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_dir;
    logic               r_half;
    logic               r_hold;
    logic [CNT_W-1:0]   r_remaining;
    logic [CNT_W-1:0]   r_pos;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   r_reload;
    logic [IDX_W-1:0]   r_idx;
    logic [PHASE_W-1:0] r_coils;
    logic [IDX_W-1:0]   w_idx_next;
    logic [CNT_W-1:0]   w_steps;
    logic [DIV_W-1:0]   w_period;
    logic [DIV_W-1:0]   w_reload_in;
    logic               w_accept;

    assign w_steps     = cmd_steps[i*CNT_W +: CNT_W];
    assign w_period    = cmd_period[i*DIV_W +: DIV_W];
    assign w_reload_in = (w_period == '0) ? '0 : w_period - 1'b1;
    assign cmd_ready[i] = r_ready & ~abort[i];
    assign w_accept     = cmd_valid[i] & cmd_ready[i];

    assign state_out[i*PHASE_W +: PHASE_W] = r_coils;
    assign pos[i*CNT_W +: CNT_W]           = r_pos;
    assign busy[i]                         = r_busy;
    assign done[i]                         = r_done;

    always_comb begin
      int n;
      n = int'(r_idx);
      if (r_dir) n = n + (r_half ? 1 : 2);
      else       n = n - (r_half ? 1 : 2);
      if (n >= IDX_N)  n = n - IDX_N;
      else if (n < 0)  n = n + IDX_N;
      w_idx_next = IDX_W'(n);
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_state     <= ST_IDLE;
        r_ready     <= 1'b0;
        r_busy      <= 1'b0;
        r_done      <= 1'b0;
        r_dir       <= 1'b0;
        r_half      <= 1'b0;
        r_hold      <= 1'b0;
        r_remaining <= '0;
        r_pos       <= '0;
        r_div       <= '0;
        r_reload    <= '0;
        r_idx       <= '0;
        r_coils     <= '0;
      end else begin
        r_done <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            r_ready <= 1'b1;
            if (w_accept) begin
              r_remaining <= w_steps;
              r_dir       <= cmd_dir[i];
              r_half      <= cmd_half[i];
              r_hold      <= cmd_hold[i];
              r_div       <= w_reload_in;
              r_reload    <= w_reload_in;
              if (w_steps == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state <= ST_RUN;
                r_ready <= 1'b0;
                r_busy  <= 1'b1;
                r_coils <= f_pattern(r_idx);
              end
            end
          end
          ST_RUN: begin
            if (abort[i]) begin
              r_state <= ST_IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              if (!r_hold) r_coils <= '0;
            end else if (r_div == '0) begin
              r_idx       <= w_idx_next;
              r_pos       <= r_dir ? r_pos + 1'b1 : r_pos - 1'b1;
              r_remaining <= r_remaining - 1'b1;
              r_div       <= r_reload;
              r_coils     <= f_pattern(w_idx_next);
              if (r_remaining == CNT_W'(1)) begin
                r_state <= ST_IDLE;
                r_ready <= 1'b1;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                if (!r_hold) r_coils <= '0;
              end
            end else begin
              r_div <= r_div - 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
